spi_master_arbiter: RTL and testbench

//  Shares one 8-bit SPI_Master among NREQ requesters. Round-robin grant; a grant is held for a multi-byte

---
 rtl/spi_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/spi_master_arbiter.sv | 146 ++++++++++++++
 tb/tb_spi_master_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared byte width and arbiter state encoding
package spi_pkg;

    localparam int SPI_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            found
);

    // Scan upward from ptr, wrapping at NREQ; the first set request wins.
    always_comb begin
        logic [IW:0] j;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = {1'b0, ptr} + (IW+1)'(i);
            if (j >= (IW+1)'(NREQ)) begin
                j = j - (IW+1)'(NREQ);
            end
            if (!found && req[j[IW-1:0]]) begin
                found               = 1'b1;
                onehot[j[IW-1:0]]   = 1'b1;
                idx                 = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin sharing of one SPI master among NREQ requesters
module spi_master_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       tx_valid,
    input  logic [NREQ-1:0]       tx_last,
    input  logic [SPI_W*NREQ-1:0] tx_data,
    output logic [NREQ-1:0]       tx_ack,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rx_valid,
    output logic [SPI_W-1:0]      rx_data,
    output logic [NREQ-1:0]       err,
    input  logic                  m_ready,
    output logic                  m_send,
    output logic [SPI_W-1:0]      m_data,
    input  logic                  m_arrived,
    input  logic [SPI_W-1:0]      m_dataO
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   rr_next;
    logic [TW-1:0]   timer_q, timer_d;
    logic            last_q, last_d;
    logic [NREQ-1:0] gnt_d, tx_ack_d, rx_valid_d, err_d;
    logic [SPI_W-1:0] m_data_d, rx_data_d;
    logic            m_send_d;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req    (req),
        .ptr    (rr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // The released owner drops to lowest priority on the next arbitration.
    assign rr_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Next-state, grant, handshake pulses, data capture and stall timer.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        timer_d    = timer_q;
        last_d     = last_q;
        gnt_d      = gnt;
        m_data_d   = m_data;
        rx_data_d  = rx_data;
        tx_ack_d   = '0;
        rx_valid_d = '0;
        err_d      = '0;
        m_send_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    gnt_d   = pick_onehot;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (tx_valid[owner_q] && m_ready) begin
                    m_data_d = tx_data[owner_q*SPI_W +: SPI_W];
                    last_d   = tx_last[owner_q];
                    m_send_d = 1'b1;
                    tx_ack_d = gnt;
                    timer_d  = '0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                timer_d = timer_q + 1'b1;
                if (m_arrived) begin
                    rx_data_d  = m_dataO;
                    rx_valid_d = gnt;
                    if (last_q) begin
                        gnt_d   = '0;
                        rr_d    = rr_next;
                        state_d = IDLE;
                    end else begin
                        state_d = OWN;
                    end
                end else if (timer_q == TMAX) begin
                    err_d   = gnt;
                    gnt_d   = '0;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            timer_q  <= '0;
            last_q   <= 1'b0;
            gnt      <= '0;
            tx_ack   <= '0;
            rx_valid <= '0;
            err      <= '0;
            m_send   <= 1'b0;
            m_data   <= '0;
            rx_data  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            timer_q  <= timer_d;
            last_q   <= last_d;
            gnt      <= gnt_d;
            tx_ack   <= tx_ack_d;
            rx_valid <= rx_valid_d;
            err      <= err_d;
            m_send   <= m_send_d;
            m_data   <= m_data_d;
            rx_data  <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - scoreboard bench for spi_master_arbiter
module tb_spi_master_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req, tx_valid, tx_last;
    logic [15:0] tx_data;
    logic [1:0]  tx_ack, gnt, rx_valid, err;
    logic [7:0]  rx_data;
    logic        m_ready, m_send, m_arrived;
    logic [7:0]  m_data, m_dataO;

    spi_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_data   (tx_data),
        .tx_ack    (tx_ack),
        .gnt       (gnt),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .err       (err),
        .m_ready   (m_ready),
        .m_send    (m_send),
        .m_data    (m_data),
        .m_arrived (m_arrived),
        .m_dataO   (m_dataO)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } src_t;

    src_t       src0[$], src1[$];
    logic [7:0] exp_send0[$], exp_send1[$], exp_rx0[$], exp_rx1[$], resp_q[$];
    logic [1:0] exp_err[$], gnt_log[$];
    logic [1:0] req_man, gnt_prev;
    logic       pend, stray;
    logic [7:0] pend_data;
    int tests, fails, inv_bad, cyc, mute_n, mr_block, slave_delay, pend_cnt;
    int rx_cnt, err_cnt, send_cnt, ack_cnt, send_cyc, err_cyc, rise_cyc, mute_cyc;

    // Negedge process: scoreboard checks, requester sources, SPI slave model.
    task automatic bench_loop();
        logic [7:0] rsp, e;
        logic [1:0] ee;
        bit         got;
        int         o;
        src_t       sd;
        forever begin
            @(negedge clk);
            cyc++;
            if (gnt === 2'b11) inv_bad++;
            if (gnt_prev === 2'b00 && gnt !== 2'b00) gnt_log.push_back(gnt);
            gnt_prev = gnt;
            if (tx_ack !== 2'b00) ack_cnt++;
            if (m_send === 1'b1) begin
                send_cnt++;
                send_cyc = cyc;
                o = (tx_ack === 2'b10) ? 1 : 0;
                tests++;
                if (tx_ack !== gnt || !(tx_ack === 2'b01 || tx_ack === 2'b10)) begin
                    fails++;
                    $display("FAIL ack_owner: tx_ack=%b gnt=%b, need one-hot equal to gnt", tx_ack, gnt);
                end
                got = 0;
                e = 8'h00;
                if (o == 0 && exp_send0.size() > 0) begin e = exp_send0.pop_front(); got = 1; end
                if (o == 1 && exp_send1.size() > 0) begin e = exp_send1.pop_front(); got = 1; end
                tests++;
                if (!got || m_data !== e) begin
                    fails++;
                    $display("FAIL m_data: req%0d m_data=%h expected %h (queued=%0d)", o, m_data, e, got);
                end
                rsp = (resp_q.size() > 0) ? resp_q.pop_front() : (m_data ^ 8'h5A);
                if (mute_n > 0) begin
                    mute_n--;
                    mute_cyc = cyc;
                end else begin
                    if (o == 0) exp_rx0.push_back(rsp);
                    else        exp_rx1.push_back(rsp);
                    pend      = 1'b1;
                    pend_cnt  = slave_delay;
                    pend_data = rsp;
                end
            end
            if (rx_valid !== 2'b00) begin
                rx_cnt++;
                tests++;
                got = 0;
                e = 8'h00;
                if (rx_valid === 2'b01 && exp_rx0.size() > 0) begin e = exp_rx0.pop_front(); got = 1; end
                if (rx_valid === 2'b10 && exp_rx1.size() > 0) begin e = exp_rx1.pop_front(); got = 1; end
                if (!got || rx_data !== e) begin
                    fails++;
                    $display("FAIL rx_data: rx_valid=%b rx_data=%h expected %h (queued=%0d)", rx_valid, rx_data, e, got);
                end
            end
            if (err !== 2'b00) begin
                err_cnt++;
                err_cyc = cyc;
                ee = (exp_err.size() > 0) ? exp_err.pop_front() : 2'b00;
                tests++;
                if (err !== ee || gnt !== 2'b00) begin
                    fails++;
                    $display("FAIL err_pulse: err=%b gnt=%b expected err=%b gnt=00", err, gnt, ee);
                end
            end
            if (tx_ack[0] === 1'b1 && src0.size() > 0) sd = src0.pop_front();
            if (tx_ack[1] === 1'b1 && src1.size() > 0) sd = src1.pop_front();
            m_arrived = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    m_arrived = 1'b1;
                    m_dataO   = pend_data;
                    pend      = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (stray) begin
                m_arrived = 1'b1;
                m_dataO   = 8'hEE;
                stray     = 1'b0;
            end
            if (mr_block > 0) begin
                m_ready = 1'b0;
                mr_block--;
            end else begin
                if (m_ready === 1'b0) rise_cyc = cyc;
                m_ready = 1'b1;
            end
            tx_valid[0]  = (src0.size() > 0);
            tx_valid[1]  = (src1.size() > 0);
            tx_data[7:0]  = (src0.size() > 0) ? src0[0].data : 8'h00;
            tx_data[15:8] = (src1.size() > 0) ? src1[0].data : 8'h00;
            tx_last[0]   = (src0.size() > 0) ? src0[0].last : 1'b0;
            tx_last[1]   = (src1.size() > 0) ? src1[0].last : 1'b0;
            req = req_man | tx_valid;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (src0.size() == 0 && src1.size() == 0 && exp_send0.size() == 0 &&
                exp_send1.size() == 0 && exp_rx0.size() == 0 && exp_rx1.size() == 0 &&
                exp_err.size() == 0 && !pend && gnt === 2'b00) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_man = 2'b11;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if ({gnt, tx_ack, rx_valid, err, m_send, m_data, rx_data} !== 25'd0) begin
            fails++;
            $display("FAIL reset_outputs: gnt=%b tx_ack=%b rx_valid=%b err=%b m_send=%b m_data=%h rx_data=%h, need all 0",
                     gnt, tx_ack, rx_valid, err, m_send, m_data, rx_data);
        end
        rst_n = 1'b1;
        tests++;
        if (gnt !== 2'b00) begin
            fails++;
            $display("FAIL gnt_at_release: gnt=%b expected 00", gnt);
        end
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (gnt !== 2'b01) begin
            fails++;
            $display("FAIL gnt_after_reset: gnt=%b expected 01", gnt);
        end
        req_man = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (gnt !== 2'b00 || err_cnt != 0) begin
            fails++;
            $display("FAIL reset_abandon: gnt=%b err_cnt=%0d expected 00 and 0", gnt, err_cnt);
        end
    endtask

    task automatic test_alternate();
        bit ok;
        logic [7:0] seq;
        gnt_log.delete();
        slave_delay = 2;
        src0.push_back('{1'b1, 8'h10}); exp_send0.push_back(8'h10);
        src0.push_back('{1'b1, 8'h12}); exp_send0.push_back(8'h12);
        src1.push_back('{1'b1, 8'h21}); exp_send1.push_back(8'h21);
        src1.push_back('{1'b1, 8'h23}); exp_send1.push_back(8'h23);
        wait_idle(400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL alternate_done: idle=%0d expected 1", ok); end
        seq = 8'h00;
        if (gnt_log.size() == 4) seq = {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]};
        tests++;
        if (gnt_log.size() != 4 || seq !== 8'b01_10_01_10) begin
            fails++;
            $display("FAIL alternate_order: grants=%0d seq=%b expected 4 and 01100110", gnt_log.size(), seq);
        end
    endtask

    task automatic test_single();
        bit ok;
        int s0, r0;
        gnt_log.delete();
        slave_delay = 3;
        s0 = send_cnt;
        r0 = rx_cnt;
        resp_q.push_back(8'h11); resp_q.push_back(8'h22); resp_q.push_back(8'h33);
        src0.push_back('{1'b0, 8'hA5}); exp_send0.push_back(8'hA5);
        src0.push_back('{1'b0, 8'h3C}); exp_send0.push_back(8'h3C);
        src0.push_back('{1'b1, 8'hFF}); exp_send0.push_back(8'hFF);
        wait_idle(400, ok);
        tests++;
        if (!ok || send_cnt - s0 != 3 || rx_cnt - r0 != 3) begin
            fails++;
            $display("FAIL single_txn: idle=%0d sends=%0d rx=%0d expected 1,3,3", ok, send_cnt - s0, rx_cnt - r0);
        end
        tests++;
        if (gnt_log.size() != 1) begin
            fails++;
            $display("FAIL single_hold: grants=%0d expected 1", gnt_log.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int r0, e0;
        logic [3:0] seq;
        gnt_log.delete();
        slave_delay = 1;
        e0 = err_cnt;
        mute_n = 1;
        exp_err.push_back(2'b10);
        src1.push_back('{1'b1, 8'h99}); exp_send1.push_back(8'h99);
        src0.push_back('{1'b1, 8'h42}); exp_send0.push_back(8'h42);
        wait_idle(400, ok);
        tests++;
        if (!ok || err_cnt - e0 != 1) begin
            fails++;
            $display("FAIL timeout_done: idle=%0d errs=%0d expected 1 and 1", ok, err_cnt - e0);
        end
        tests++;
        if (err_cyc - mute_cyc != TIMEOUT) begin
            fails++;
            $display("FAIL timeout_latency: %0d cycles expected %0d", err_cyc - mute_cyc, TIMEOUT);
        end
        seq = 4'b0000;
        if (gnt_log.size() == 2) seq = {gnt_log[0], gnt_log[1]};
        tests++;
        if (gnt_log.size() != 2 || seq !== 4'b10_01) begin
            fails++;
            $display("FAIL timeout_next_owner: grants=%0d seq=%b expected 2 and 1001", gnt_log.size(), seq);
        end
        r0 = rx_cnt;
        stray = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        tests++;
        if (rx_cnt != r0) begin
            fails++;
            $display("FAIL stray_arrived: rx pulses=%0d expected 0", rx_cnt - r0);
        end
    endtask

    task automatic test_own_drop();
        bit seen;
        int e0, a0;
        e0 = err_cnt;
        a0 = ack_cnt;
        seen = 0;
        req_man = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (gnt === 2'b01) begin seen = 1; break; end
        end
        req_man = 2'b00;
        tests++;
        if (!seen) begin fails++; $display("FAIL own_grant: gnt=%b expected 01", gnt); end
        @(posedge clk); #2;
        tests++;
        if (gnt !== 2'b00) begin fails++; $display("FAIL own_drop: gnt=%b expected 00", gnt); end
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (err_cnt != e0 || ack_cnt != a0) begin
            fails++;
            $display("FAIL own_drop_quiet: errs=%0d acks=%0d expected 0 and 0", err_cnt - e0, ack_cnt - a0);
        end
    endtask

    task automatic test_xfer_drop();
        bit seen, ok;
        slave_delay = 3;
        seen = 0;
        src0.push_back('{1'b0, 8'h77}); exp_send0.push_back(8'h77);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (rx_valid[0] === 1'b1) begin seen = 1; break; end
        end
        tests++;
        if (!seen || gnt !== 2'b01) begin
            fails++;
            $display("FAIL xfer_drop_rx: rx_seen=%0d gnt=%b expected 1 and 01", seen, gnt);
        end
        @(posedge clk); #2;
        tests++;
        if (gnt !== 2'b00) begin fails++; $display("FAIL xfer_drop_release: gnt=%b expected 00", gnt); end
        wait_idle(50, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL xfer_drop_idle: idle=%0d expected 1", ok); end
    endtask

    task automatic test_ready_stall();
        bit ok;
        int s0, a0;
        slave_delay = 1;
        s0 = send_cnt;
        a0 = ack_cnt;
        mr_block = 5;
        src0.push_back('{1'b1, 8'hC3}); exp_send0.push_back(8'hC3);
        wait_idle(100, ok);
        tests++;
        if (!ok || send_cnt - s0 != 1 || ack_cnt - a0 != 1) begin
            fails++;
            $display("FAIL stall_counts: idle=%0d sends=%0d acks=%0d expected 1,1,1", ok, send_cnt - s0, ack_cnt - a0);
        end
        tests++;
        if (send_cyc != rise_cyc + 1) begin
            fails++;
            $display("FAIL stall_timing: send at %0d, m_ready rose at %0d, expected one cycle after", send_cyc, rise_cyc);
        end
    endtask

    initial begin
        tests = 0; fails = 0; inv_bad = 0; cyc = 0; mute_n = 0; mr_block = 0;
        slave_delay = 2; pend_cnt = 0; rx_cnt = 0; err_cnt = 0; send_cnt = 0;
        ack_cnt = 0; send_cyc = 0; err_cyc = 0; rise_cyc = 0; mute_cyc = 0;
        pend = 1'b0; stray = 1'b0; pend_data = 8'h00;
        req_man = 2'b00; gnt_prev = 2'b00;
        req = 2'b00; tx_valid = 2'b00; tx_last = 2'b00; tx_data = 16'h0000;
        m_ready = 1'b1; m_arrived = 1'b0; m_dataO = 8'h00;
        fork
            bench_loop();
        join_none
        test_reset();
        test_alternate();
        test_single();
        test_timeout();
        test_own_drop();
        test_xfer_drop();
        test_ready_stall();
        tests++;
        if (inv_bad != 0) begin
            fails++;
            $display("FAIL gnt_onehot: cycles with gnt=11: %0d expected 0", inv_bad);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
